// File: rtl/can_tx_arbiter.sv
// can_tx_arbiter: round-robin frame scheduler for a shared byte-serial
// transmitter. Grants one of four requesters, then sends a header byte,
// 0-15 payload bytes and, when CAN_TX_ARB_CHECK_EN is defined, an XOR
// check byte. A per-byte watchdog aborts a frame whose transmitter never
// reports completion.
module can_tx_arbiter #(
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic        i_Clock,
    input  logic        i_Rst_L,
    input  logic [3:0]  i_Req,
    input  logic [15:0] i_Req_Len,
    input  logic [31:0] i_Req_Byte,
    output logic [3:0]  o_Req_Ack,
    output logic [1:0]  o_Grant,
    output logic        o_Busy,
    output logic        o_Frame_Done,
    output logic        o_Err,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done
);

    localparam int WD_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [3:0]        rem_q, rem_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              done_prev_q;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [3:0]        ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;
`ifdef CAN_TX_ARB_CHECK_EN
    logic [7:0]        xor_q, xor_d;
    logic              chk_sent_q, chk_sent_d;
`endif

    logic [1:0]        pick;
    logic              any_req;
    logic [3:0]        pick_len;
    logic [7:0]        cur_byte;
    logic              done_rise;
    logic              end_frame;

    assign done_rise = i_Tx_Done & ~done_prev_q;
    assign pick_len  = i_Req_Len[{pick, 2'b00} +: 4];
    assign cur_byte  = i_Req_Byte[{grant_q, 3'b000} +: 8];

    // Round-robin search: first set request at or after ptr, wrapping 3->0.
    always_comb begin
        pick    = ptr_q;
        any_req = 1'b0;
        // Walk downward so the smallest offset from ptr is the last writer.
        for (int i = 3; i >= 0; i--) begin
            if (i_Req[ptr_q + 2'(i)]) begin
                pick    = ptr_q + 2'(i);
                any_req = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        rem_d        = rem_q;
        wd_d         = wd_q;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        ack_d        = 4'b0000;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        end_frame    = 1'b0;
`ifdef CAN_TX_ARB_CHECK_EN
        xor_d        = xor_q;
        chk_sent_d   = chk_sent_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d   = pick;
                    rem_d     = pick_len;
                    tx_byte_d = {pick, 2'b00, pick_len};
                    busy_d    = 1'b1;
                    state_d   = ISSUE;
`ifdef CAN_TX_ARB_CHECK_EN
                    xor_d      = {pick, 2'b00, pick_len};
                    chk_sent_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                // Only hand over a byte once the transmitter is fully idle.
                if (!i_Tx_Active && !i_Tx_Done) begin
                    tx_dv_d = 1'b1;
                    wd_d    = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    if (rem_q != 4'd0) begin
                        tx_byte_d = cur_byte;
                        ack_d     = 4'b0001 << grant_q;
                        rem_d     = rem_q - 4'd1;
                        state_d   = ISSUE;
`ifdef CAN_TX_ARB_CHECK_EN
                        xor_d     = xor_q ^ cur_byte;
`endif
                    end else begin
`ifdef CAN_TX_ARB_CHECK_EN
                        if (!chk_sent_q) begin
                            tx_byte_d  = xor_q;
                            chk_sent_d = 1'b1;
                            state_d    = ISSUE;
                        end else begin
                            end_frame = 1'b1;
                        end
`else
                        end_frame = 1'b1;
`endif
                    end
                end else if (wd_q == WD_W'(TIMEOUT_CLKS - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = grant_q + 2'd1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_frame) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            ptr_d        = grant_q + 2'd1;
            state_d      = IDLE;
        end
    end

    // State and output registers; reset drops everything back to IDLE.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            grant_q      <= 2'd0;
            rem_q        <= 4'd0;
            wd_q         <= '0;
            done_prev_q  <= 1'b0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            ack_q        <= 4'b0000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef CAN_TX_ARB_CHECK_EN
            xor_q        <= 8'h00;
            chk_sent_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            rem_q        <= rem_d;
            wd_q         <= wd_d;
            done_prev_q  <= i_Tx_Done;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef CAN_TX_ARB_CHECK_EN
            xor_q        <= xor_d;
            chk_sent_q   <= chk_sent_d;
`endif
        end
    end

    assign o_Req_Ack    = ack_q;
    assign o_Grant      = grant_q;
    assign o_Busy       = busy_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Err        = err_q;
    assign o_Tx_DV      = tx_dv_q;
    assign o_Tx_Byte    = tx_byte_q;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed testbench for can_tx_arbiter with a simple transmitter model
// and per-requester payload tables.
module tb_can_tx_arbiter;

    localparam int TIMEOUT   = 64;
    localparam int BYTE_CLKS = 4;
`ifdef CAN_TX_ARB_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        i_Clock = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic [3:0]  i_Req = 4'b0000;
    logic [15:0] i_Req_Len = 16'h0000;
    logic [31:0] i_Req_Byte = 32'h0;
    logic [3:0]  o_Req_Ack;
    logic [1:0]  o_Grant;
    logic        o_Busy;
    logic        o_Frame_Done;
    logic        o_Err;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic        i_Tx_Active = 1'b0;
    logic        i_Tx_Done = 1'b0;

    can_tx_arbiter #(.TIMEOUT_CLKS(TIMEOUT)) dut (
        .i_Clock      (i_Clock),
        .i_Rst_L      (i_Rst_L),
        .i_Req        (i_Req),
        .i_Req_Len    (i_Req_Len),
        .i_Req_Byte   (i_Req_Byte),
        .o_Req_Ack    (o_Req_Ack),
        .o_Grant      (o_Grant),
        .o_Busy       (o_Busy),
        .o_Frame_Done (o_Frame_Done),
        .o_Err        (o_Err),
        .o_Tx_DV      (o_Tx_DV),
        .o_Tx_Byte    (o_Tx_Byte),
        .i_Tx_Active  (i_Tx_Active),
        .i_Tx_Done    (i_Tx_Done)
    );

    always #5 i_Clock = ~i_Clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Monitor / transmitter model / requester state
    int         cyc = 0;
    int         first_dv_cyc = 0;
    int         err_cyc = 0;
    int         gate_viol = 0;
    int         done_edges = 0;
    int         fd_edge = 0;
    int         fd_cnt = 0;
    int         err_cnt = 0;
    int         ack_cnt [4];
    int         pidx [4];
    logic [7:0] pay [4][16];
    logic [7:0] dv_log [$];
    logic [1:0] fd_grants [$];
    int         tx_cnt = 0;
    int         done_hold = 0;
    bit         tx_stuck = 1'b0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            ack_cnt[k] = 0;
            pidx[k]    = 0;
            for (int j = 0; j < 16; j++) pay[k][j] = 8'h00;
        end
    end

    // Sample outputs on the falling edge and drive the transmitter/requesters.
    always @(negedge i_Clock) begin
        cyc++;
        if (o_Tx_DV && (i_Tx_Done || i_Tx_Active)) gate_viol++;
        if (o_Tx_DV) begin
            if (dv_log.size() == 0) first_dv_cyc = cyc;
            dv_log.push_back(o_Tx_Byte);
        end
        for (int k = 0; k < 4; k++) begin
            if (o_Req_Ack[k]) begin
                ack_cnt[k]++;
                if (pidx[k] < 15) pidx[k]++;
            end
        end
        if (o_Frame_Done) begin
            fd_cnt++;
            fd_edge = done_edges;
            fd_grants.push_back(o_Grant);
        end
        if (o_Err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                i_Tx_Active = 1'b0;
                i_Tx_Done   = 1'b1;
                done_hold   = 2;
                done_edges++;
            end
        end else if (done_hold > 0) begin
            done_hold--;
            if (done_hold == 0) i_Tx_Done = 1'b0;
        end
        if (o_Tx_DV) begin
            i_Tx_Active = 1'b1;
            if (!tx_stuck) tx_cnt = BYTE_CLKS;
        end
        for (int k = 0; k < 4; k++) i_Req_Byte[8*k +: 8] = pay[k][pidx[k]];
    end

    task automatic step();
        @(negedge i_Clock);
        #1;
    endtask

    task automatic clear_logs();
        dv_log.delete();
        fd_grants.delete();
        for (int k = 0; k < 4; k++) begin
            ack_cnt[k] = 0;
            pidx[k]    = 0;
        end
        fd_cnt     = 0;
        err_cnt    = 0;
        done_edges = 0;
        gate_viol  = 0;
    endtask

    task automatic do_reset();
        i_Rst_L     = 1'b0;
        i_Req       = 4'b0000;
        tx_stuck    = 1'b0;
        tx_cnt      = 0;
        done_hold   = 0;
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b0;
        repeat (3) step();
        i_Rst_L = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic wait_busy(input string name, input int budget);
        int t;
        t = 0;
        while (!o_Busy && t < budget) begin step(); t++; end
        n_cmp++;
        if (!o_Busy) begin
            n_mis++;
            $display("FAIL %s: busy not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_fd(input string name, input int n, input int budget);
        int t;
        t = 0;
        while (fd_cnt < n && err_cnt == 0 && t < budget) begin step(); t++; end
        n_cmp++;
        if (fd_cnt < n) begin
            n_mis++;
            $display("FAIL %s: frame_done count %0d, required %0d", name, fd_cnt, n);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({o_Req_Ack, o_Grant, o_Busy, o_Frame_Done, o_Err, o_Tx_DV, o_Tx_Byte} !== 19'h0) begin
            n_mis++;
            $display("FAIL reset_outputs: got 0x%0h required 0x0",
                     {o_Req_Ack, o_Grant, o_Busy, o_Frame_Done, o_Err, o_Tx_DV, o_Tx_Byte});
        end
        do_reset();
        repeat (5) step();
        chk("reset_idle_busy", int'(o_Busy), 0);
        chk("reset_idle_dv_count", dv_log.size(), 0);
    endtask

    task automatic test_single();
        logic [7:0] exp_b [4];
        int c0;
        do_reset();
        pay[1][0] = 8'h12;
        pay[1][1] = 8'h34;
        i_Req_Byte[15:8] = 8'h12;
        exp_b[0] = 8'h42; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h64;
        i_Req_Len = 16'h0020;
        i_Req     = 4'b0010;
        c0 = cyc;
        wait_busy("single_busy", 10);
        i_Req = 4'b0000;
        wait_fd("single_fd", 1, 200);
        chk("single_latency", first_dv_cyc - c0, 2);
        chk("single_dv_count", dv_log.size(), 3 + CHK);
        for (int i = 0; i < 3 + CHK; i++)
            if (i < dv_log.size()) chk($sformatf("single_byte%0d", i), int'(dv_log[i]), int'(exp_b[i]));
        chk("single_ack1", ack_cnt[1], 2);
        chk("single_ack_other", ack_cnt[0] + ack_cnt[2] + ack_cnt[3], 0);
        chk("single_fd_edge", fd_edge, 3 + CHK);
        chk("single_grant", int'(o_Grant), 1);
        chk("single_busy_clear", int'(o_Busy), 0);
    endtask

    task automatic test_tx_model();
        do_reset();
        pay[0][0] = 8'hA1; pay[0][1] = 8'hB2; pay[0][2] = 8'hC3;
        i_Req_Len = 16'h0003;
        i_Req     = 4'b0001;
        wait_busy("txm_busy", 10);
        i_Req = 4'b0000;
        wait_fd("txm_fd", 1, 200);
        chk("txm_gate_viol", gate_viol, 0);
        chk("txm_dv_per_byte", dv_log.size(), done_edges);
        chk("txm_dv_count", dv_log.size(), 4 + CHK);
    endtask

    task automatic test_round_robin();
        int per;
        do_reset();
        per = 1 + CHK;
        i_Req_Len = 16'h0000;
        i_Req     = 4'b1111;
        wait_fd("rr_fd", 5, 400);
        i_Req = 4'b0000;
        repeat (10) step();
        chk("rr_frames", fd_grants.size(), 5);
        for (int f = 0; f < 5; f++) begin
            if (f < fd_grants.size()) chk($sformatf("rr_grant%0d", f), int'(fd_grants[f]), f % 4);
            if (f * per < dv_log.size())
                chk($sformatf("rr_header%0d", f), int'(dv_log[f * per]), (f % 4) << 6);
        end
        chk("rr_dv_count", dv_log.size(), 5 * per);
        chk("rr_gate_viol", gate_viol, 0);
    endtask

    task automatic test_len15();
        logic [7:0] x;
        do_reset();
        for (int j = 0; j < 16; j++) pay[3][j] = 8'(j * 17 + 5);
        i_Req_Byte[31:24] = pay[3][0];
        x = 8'hCF;
        for (int j = 0; j < 15; j++) x = x ^ pay[3][j];
        i_Req_Len = 16'hF000;
        i_Req     = 4'b1000;
        wait_busy("len15_busy", 10);
        i_Req = 4'b0000;
        wait_fd("len15_fd", 1, 600);
        chk("len15_dv_count", dv_log.size(), 16 + CHK);
        chk("len15_ack3", ack_cnt[3], 15);
        if (dv_log.size() >= 16) begin
            chk("len15_header", int'(dv_log[0]), 8'hCF);
            chk("len15_last", int'(dv_log[15]), int'(pay[3][14]));
        end
        if (CHK == 1 && dv_log.size() >= 17) chk("len15_check", int'(dv_log[16]), int'(x));
    endtask

    task automatic test_watchdog();
        int t;
        do_reset();
        tx_stuck  = 1'b1;
        i_Req_Len = 16'h0300;
        i_Req     = 4'b0100;
        wait_busy("wd_busy", 10);
        i_Req = 4'b0000;
        t = 0;
        while (err_cnt == 0 && t < TIMEOUT + 50) begin step(); t++; end
        chk("wd_err_count", err_cnt, 1);
        chk("wd_err_delay", err_cyc - first_dv_cyc, TIMEOUT);
        chk("wd_busy_clear", int'(o_Busy), 0);
        chk("wd_no_fd", fd_cnt, 0);
        chk("wd_no_ack", ack_cnt[2], 0);
        chk("wd_dv_count", dv_log.size(), 1);
        tx_stuck    = 1'b0;
        tx_cnt      = 0;
        i_Tx_Active = 1'b0;
        step();
        clear_logs();
        i_Req_Len = 16'h0000;
        i_Req     = 4'b1100;
        wait_busy("wd_next_busy", 10);
        i_Req = 4'b0000;
        wait_fd("wd_next_fd", 1, 200);
        if (fd_grants.size() > 0) chk("wd_next_grant", int'(fd_grants[0]), 3);
        if (dv_log.size() > 0) chk("wd_next_header", int'(dv_log[0]), 8'hC0);
    endtask

    task automatic test_reset_mid();
        int t;
        int n;
        do_reset();
        for (int j = 0; j < 5; j++) pay[2][j] = 8'(8'h50 + j);
        i_Req_Byte[23:16] = pay[2][0];
        i_Req_Len = 16'h0500;
        i_Req     = 4'b0100;
        wait_busy("rst_busy", 10);
        i_Req = 4'b0000;
        t = 0;
        while (dv_log.size() < 3 && t < 200) begin step(); t++; end
        chk("rst_reached_byte2", dv_log.size(), 3);
        i_Rst_L = 1'b0;
        #1;
        n_cmp++;
        if ({o_Req_Ack, o_Grant, o_Busy, o_Frame_Done, o_Err, o_Tx_DV, o_Tx_Byte} !== 19'h0) begin
            n_mis++;
            $display("FAIL rst_mid_outputs: got 0x%0h required 0x0",
                     {o_Req_Ack, o_Grant, o_Busy, o_Frame_Done, o_Err, o_Tx_DV, o_Tx_Byte});
        end
        repeat (2) step();
        i_Rst_L = 1'b1;
        n = dv_log.size();
        repeat (30) step();
        chk("rst_no_dv_after", dv_log.size(), n);
        chk("rst_idle_busy", int'(o_Busy), 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_tx_model();
        test_round_robin();
        test_len15();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/can_tx_arbiter.md
# can_tx_arbiter

Round-robin frame scheduler in front of the byte-serial transmitter. It grants the shared transmitter to one of four requesters at a time and sequences one frame per grant: a header byte, 0–15 payload bytes, and an optional check byte. It issues each byte with a one-cycle valid pulse and waits for the transmitter's completion before issuing the next. It sits between the message sources and the transmitter, and owns the transmitter's `i_Tx_DV`/`i_Tx_Byte` inputs exclusively.

## Interface
- `TIMEOUT_CLKS`, 1024: per-byte watchdog limit in clocks. Must exceed one full byte time (10 × bit period).
- One clock; reset is asynchronous and active-low.
- `i_Clock`  in  1  system clock, rising edge.
- `i_Rst_L`  in  1  asynchronous active-low reset.
- `i_Req`  in  4  per-requester frame request (level).
- `i_Req_Len`  in  16  4-bit payload length per requester; requester k uses [4k+3:4k].
- `i_Req_Byte`  in  32  current payload byte per requester; requester k uses [8k+7:8k].
- `o_Req_Ack`  out  4  one-cycle pulse; the granted requester's current byte was consumed.
- `o_Grant`  out  2  ID of the current/last granted requester.
- `o_Busy`  out  1  high while a frame is in progress.
- `o_Frame_Done`  out  1  one-cycle pulse; frame completed.
- `o_Err`  out  1  one-cycle pulse; frame aborted by watchdog.
- `o_Tx_DV`  out  1  byte-valid pulse to the transmitter.
- `o_Tx_Byte`  out  8  byte to the transmitter; stable from the DV pulse until the next load.
- `i_Tx_Active`  in  1  transmitter busy.
- `i_Tx_Done`  in  1  transmitter done; level may stay high for 2 cycles.

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- **IDLE**
  - If any `i_Req` bit is high, grant the first set bit at or after the priority pointer `ptr`, searching upward with wrap 3→0.
  - Latch the grant ID `g` and `len = i_Req_Len[g]`.
  - Load the header byte `{g[1:0], 2'b00, len[3:0]}` into `o_Tx_Byte`.
  - Set `o_Busy`, then go to ISSUE.
- **ISSUE**
  - When `i_Tx_Active==0` and `i_Tx_Done==0`, pulse `o_Tx_DV` for one cycle and go to WAIT_DONE.
  - Otherwise hold in ISSUE with no timeout.
- **WAIT_DONE**
  - Wait for the rising edge of `i_Tx_Done`, detected against a registered copy.
  - On the edge, if payload bytes remain: load `i_Req_Byte[g]` into `o_Tx_Byte`, pulse `o_Req_Ack[g]` in the same cycle, decrement the remaining count, and go to ISSUE.
  - On the edge, if no payload bytes remain (and the check byte is already sent or disabled): pulse `o_Frame_Done`, clear `o_Busy`, set `ptr = g+1` (mod 4), and go to IDLE.
- **Watchdog:** a counter clears on entry to WAIT_DONE. On reaching `TIMEOUT_CLKS-1` without a done edge:
  - pulse `o_Err` and clear `o_Busy`;
  - set `ptr = g+1`;
  - go to IDLE with no ack for any unsent bytes.
- **Request handling**
  - `i_Req` is sampled only in IDLE. Deasserting it mid-frame does not shorten the frame.
  - `i_Req_Len` is sampled only at grant.
- **Length boundaries**
  - `len=0`: the frame is header only (plus the check byte if enabled).
  - `len=15`: the frame carries 15 payload bytes.
- **Done edge in other states:** a done edge arriving in IDLE or ISSUE is ignored.

## Timing
- **Reset values:** all outputs 0, `ptr=0`, state IDLE.
- **Reset mid-frame:** return to IDLE immediately and issue no further DV. The transmitter may finish its current byte; the ISSUE gate prevents overlap on the next frame.
- **Grant latency:** request high in IDLE at edge N → ISSUE after edge N. `o_Tx_DV` is high during the cycle after edge N+1 if the transmitter is idle.
- **Inter-byte gap:** done rising edge → next DV no earlier than the first cycle with `i_Tx_Done==0` and `i_Tx_Active==0`.
- **Registered outputs:** all outputs are registered, with no combinational input-to-output paths.
- **Simultaneous requests:** the round-robin pointer decides the grant.
- **Watchdog range:** the counter is ≥ `clog2(TIMEOUT_CLKS)` bits and never wraps.

## Configuration
- Macro: `CAN_TX_ARB_CHECK_EN`.
- **Defined:** after the last payload byte, one extra byte is sent: the XOR of the header and all payload bytes. No `o_Req_Ack` accompanies it, and `o_Frame_Done` follows its done edge.
- **Undefined:** there is no check byte and no XOR register, and the frame ends after the last payload byte.

## Test plan
- **Single request, macro on:** requester 1, len=2, bytes 0x12 then 0x34 → DV bytes 0x42, 0x12, 0x34, 0x64. Exactly 2 acks on bit 1. `o_Frame_Done` follows the 4th done edge. `o_Grant=1`.
- **Single request, macro off:** same stimulus → 3 bytes. `o_Frame_Done` follows the 3rd done edge.
- **Round-robin:** `i_Req=4'b1111` held, len=0 → grants 0,1,2,3,0 in order. Headers 0x00, 0x40, 0x80, 0xC0.
- **Transmitter model:** done high for 2 cycles → no DV while `i_Tx_Done` or `i_Tx_Active` is high, and exactly one DV per byte.
- **Watchdog:** `i_Tx_Done` stuck low after the header DV → `o_Err` exactly `TIMEOUT_CLKS` cycles after WAIT_DONE entry. No `o_Frame_Done`. The next grant goes to g+1.
- **Reset mid-payload:** `i_Rst_L` low during byte 2 of 5 → all outputs 0 immediately. After release, no DV until a new request.
